// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the dual-port RAM port-B arbiter.
//   boot_state_e : boot sequencer states (BOOT until the image is loaded, then RUN)
//   req_idx_t    : index of a requester (0 = core LSU, 1 = loader/debug master)
//   in_range()   : true when a byte address falls inside the RAM
package dp_ram_pkg;

  typedef enum logic {BOOT, RUN} boot_state_e;

  typedef logic req_idx_t;

  // The RAM holds 2^maxblksize 32-bit words, so it covers byte addresses
  // below 2^(maxblksize+2). Callers zero-extend their address to 64 bits.
  function automatic logic in_range(input logic [63:0] addr, input int maxblksize);
    return (addr >> (maxblksize + 2)) == 64'd0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a request mask.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req[1:0]      : raw requests
//   mask[1:0]     : requests allowed to compete this cycle
//   gnt[1:0]      : one-hot (or zero) grant, combinational from req/mask/pointer
// The priority pointer names the preferred requester and flips to the other
// requester after every grant. Grants are forced to zero while in reset.
module rr_arb2
  import dp_ram_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  req_idx_t   ptr;
  logic [1:0] eligible;

  assign eligible = req & mask & {2{rst_ni}};

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    if (eligible == 2'b11) gnt[ptr] = 1'b1;
    else                   gnt = eligible;
  end

  // NOTE: state flops are updated only with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     ptr <= 1'b0;
    else if (|gnt)   ptr <= gnt[0];  // granted 0 -> prefer 1, granted 1 -> prefer 0
  end

endmodule

// File: rtl/dp_ram_arbiter.sv
// Port-B arbiter and boot sequencer for the dual-port program/data RAM.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   req/gnt/addr/we/be/wdata : OBI-style request side of requester 0 (core LSU)
//                              and requester 1 (loader/debug master)
//   rvalid/rdata/err         : response side, one cycle after the grant
//   ram_*                    : RAM port B pins; read data returns one cycle after en
//   loader_done_i            : loader has finished writing the image (level)
//   fetch_enable_o           : releases core instruction fetch once in RUN
// In BOOT only the loader is served. The block moves to RUN once the loader
// is done, nothing is granted that cycle and no response is outstanding, and
// never returns to BOOT except through reset.
module dp_ram_arbiter
  import dp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 22,
  parameter int MAXBLKSIZE = 17
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req0_i,
  output logic                  gnt0_o,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic                  we0_i,
  input  logic [3:0]            be0_i,
  input  logic [31:0]           wdata0_i,
  output logic                  rvalid0_o,
  output logic [31:0]           rdata0_o,
  output logic                  err0_o,
  input  logic                  req1_i,
  output logic                  gnt1_o,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic                  we1_i,
  input  logic [3:0]            be1_i,
  input  logic [31:0]           wdata1_i,
  output logic                  rvalid1_o,
  output logic [31:0]           rdata1_o,
  output logic                  err1_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i,
  input  logic                  loader_done_i,
  output logic                  fetch_enable_o
);

  boot_state_e           state, state_next;
  logic [1:0]            mask, gnt;
  logic                  any_gnt;
  req_idx_t              sel;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we, sel_in_range;
  logic [3:0]            sel_be;
  logic [31:0]           sel_wdata;

  logic                  resp_valid, resp_err, resp_we;
  req_idx_t              resp_owner;
  logic                  resp_ok;

  // ---------------- arbitration ----------------
  assign mask = (state == BOOT) ? 2'b10 : 2'b11;

  rr_arb2 u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req    ({req1_i, req0_i}),
    .mask   (mask),
    .gnt    (gnt)
  );

  assign gnt0_o  = gnt[0];
  assign gnt1_o  = gnt[1];
  assign any_gnt = |gnt;
  assign sel     = gnt[1];

  assign sel_addr  = sel ? addr1_i  : addr0_i;
  assign sel_we    = sel ? we1_i    : we0_i;
  assign sel_be    = sel ? be1_i    : be0_i;
  assign sel_wdata = sel ? wdata1_i : wdata0_i;

  assign sel_in_range = in_range({{(64-ADDR_WIDTH){1'b0}}, sel_addr}, MAXBLKSIZE);

  // Out-of-range transfers are still granted but never reach the RAM.
  assign ram_en_o    = any_gnt & sel_in_range;
  assign ram_we_o    = any_gnt & sel_we;
  assign ram_be_o    = any_gnt ? sel_be : 4'h0;
  assign ram_addr_o  = sel_addr;
  assign ram_wdata_o = sel_wdata;

  // ---------------- boot sequencer ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= BOOT;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      // Wait for a quiet cycle so no loader transfer straddles the switch.
      BOOT:    if (loader_done_i && !any_gnt && !resp_valid) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  assign fetch_enable_o = (state == RUN);

  // ---------------- response tracking ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid <= 1'b0;
      resp_owner <= 1'b0;
      resp_err   <= 1'b0;
      resp_we    <= 1'b0;
    end else begin
      resp_valid <= any_gnt;
      if (any_gnt) begin
        resp_owner <= sel;
        resp_err   <= ~sel_in_range;
        resp_we    <= sel_we;
      end
    end
  end

  // Only a successful read forwards RAM data; writes and errors return zero.
  assign resp_ok = resp_valid & ~resp_err & ~resp_we;

  assign rvalid0_o = resp_valid & (resp_owner == 1'b0);
  assign rvalid1_o = resp_valid & (resp_owner == 1'b1);
  assign err0_o    = rvalid0_o & resp_err;
  assign err1_o    = rvalid1_o & resp_err;
  assign rdata0_o  = (rvalid0_o & resp_ok) ? ram_rdata_i : 32'h0;
  assign rdata1_o  = (rvalid1_o & resp_ok) ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_dp_ram_arbiter.sv
// Randomized self-checking bench for dp_ram_arbiter. A transaction-level
// reference (pending requests, preference bit, boot flag, shadow memory)
// predicts grants, RAM enables and responses every cycle; a behavioural RAM
// sits on port B.
module tb_dp_ram_arbiter;

  localparam int AW = 22;
  localparam logic [AW-1:0] RAM_LIMIT = 22'h80000;  // 2^(17+2)

  typedef struct packed {
    logic          vld;
    logic          we;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_ni;
  logic req0, gnt0, we0, rvalid0, err0;
  logic req1, gnt1, we1, rvalid1, err1;
  logic [AW-1:0] addr0, addr1, ram_addr;
  logic [3:0] be0, be1, ram_be;
  logic [31:0] wdata0, wdata1, rdata0, rdata1, ram_wdata, ram_rdata;
  logic ram_en, ram_we, loader_done, fetch_en;

  always #5 clk = ~clk;

  dp_ram_arbiter #(.ADDR_WIDTH(AW), .MAXBLKSIZE(17)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req0_i(req0), .gnt0_o(gnt0), .addr0_i(addr0), .we0_i(we0), .be0_i(be0),
    .wdata0_i(wdata0), .rvalid0_o(rvalid0), .rdata0_o(rdata0), .err0_o(err0),
    .req1_i(req1), .gnt1_o(gnt1), .addr1_i(addr1), .we1_i(we1), .be1_i(be1),
    .wdata1_i(wdata1), .rvalid1_o(rvalid1), .rdata1_o(rdata1), .err1_o(err1),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_be_o(ram_be),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .loader_done_i(loader_done), .fetch_enable_o(fetch_en)
  );

  // ---------------- behavioural RAM on port B ----------------
  bit [31:0]   ram_mem [0:(1<<17)-1];
  logic [31:0] ram_w;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        ram_w = ram_mem[ram_addr[18:2]];
        for (int b = 0; b < 4; b++) if (ram_be[b]) ram_w[8*b +: 8] = ram_wdata[8*b +: 8];
        ram_mem[ram_addr[18:2]] <= ram_w;
      end
      ram_rdata <= ram_mem[ram_addr[18:2]];
    end else begin
      ram_rdata <= $urandom;  // garbage whenever the RAM was not read
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit [31:0] ref_mem [0:(1<<17)-1];
  txn_t pend [2];
  bit   m_run, m_ptr, m_rv, m_rown, m_rerr;
  logic [31:0] m_rdata;
  bit   rand_en;
  int   load;

  // observations from the most recent step, for directed checks
  logic obs_fe, obs_any, obs_gi, obs_ram_en, obs_err0, obs_rvalid1;
  logic [31:0] obs_rdata0, obs_rdata1;

  function automatic txn_t rand_txn();
    txn_t t;
    int   r;
    t.vld   = 1'b1;
    t.we    = $urandom_range(0, 1) == 1;
    t.be    = 4'($urandom_range(0, 15));
    t.wdata = $urandom;
    r = $urandom_range(0, 19);
    if (r == 0)      t.addr = RAM_LIMIT - 22'd4;            // last word in range
    else if (r == 1) t.addr = RAM_LIMIT;                    // first word out of range
    else if (r == 2) t.addr = 22'h3FFFFC;                   // top of address space
    else             t.addr = AW'($urandom_range(0, 31) * 4);
    return t;
  endfunction

  task automatic drive();
    req0 = pend[0].vld; addr0 = pend[0].addr; we0 = pend[0].we;
    be0  = pend[0].be;  wdata0 = pend[0].wdata;
    req1 = pend[1].vld; addr1 = pend[1].addr; we1 = pend[1].we;
    be1  = pend[1].be;  wdata1 = pend[1].wdata;
  endtask

  task automatic model_reset();
    m_run = 0; m_ptr = 0; m_rv = 0; m_rown = 0; m_rerr = 0; m_rdata = '0;
  endtask

  // One clock cycle: predict and compare on the falling edge, advance the
  // model, then present the next requests just after the rising edge.
  task automatic step();
    logic g0, g1, gi, any, oor, own0, own1, trans;
    txn_t tx;
    @(negedge clk);
    if (!m_run) begin
      g0 = 1'b0; g1 = pend[1].vld;
    end else if (pend[0].vld && pend[1].vld) begin
      g0 = ~m_ptr; g1 = m_ptr;
    end else begin
      g0 = pend[0].vld; g1 = pend[1].vld;
    end
    any = g0 | g1;
    gi  = g1;
    tx  = pend[gi];
    oor = tx.addr >= RAM_LIMIT;

    check("gnt0", gnt0, g0);
    check("gnt1", gnt1, g1);
    check("ram_en", ram_en, any & ~oor);
    check("fetch_en", fetch_en, m_run);
    if (any) begin
      check("ram_addr", ram_addr, tx.addr);
      check("ram_we", ram_we, tx.we);
      check("ram_be", ram_be, tx.be);
      if (tx.we) check("ram_wdata", ram_wdata, tx.wdata);
    end else begin
      check("idle_we", ram_we, 1'b0);
      check("idle_be", ram_be, 4'h0);
    end

    own0 = m_rv & ~m_rown;
    own1 = m_rv & m_rown;
    check("rvalid0", rvalid0, own0);
    check("rvalid1", rvalid1, own1);
    check("err0", err0, own0 & m_rerr);
    check("err1", err1, own1 & m_rerr);
    check("rdata0", rdata0, own0 ? m_rdata : 32'h0);
    check("rdata1", rdata1, own1 ? m_rdata : 32'h0);

    obs_fe = fetch_en; obs_any = gnt0 | gnt1; obs_gi = gnt1; obs_ram_en = ram_en;
    obs_err0 = err0; obs_rdata0 = rdata0; obs_rdata1 = rdata1; obs_rvalid1 = rvalid1;

    trans = !m_run && loader_done && !any && !m_rv;
    if (any) begin
      m_rown  = gi;
      m_rerr  = oor;
      m_rdata = (tx.we || oor) ? 32'h0 : ref_mem[tx.addr[18:2]];
      if (tx.we && !oor)
        for (int b = 0; b < 4; b++)
          if (tx.be[b]) ref_mem[tx.addr[18:2]][8*b +: 8] = tx.wdata[8*b +: 8];
      m_ptr = ~gi;
    end
    m_rv = any;
    if (trans) m_run = 1;

    @(posedge clk);
    #1;
    if (g0) pend[0].vld = 1'b0;
    if (g1) pend[1].vld = 1'b0;
    if (rand_en)
      for (int i = 0; i < 2; i++)
        if (!pend[i].vld && $urandom_range(0, 99) < load) pend[i] = rand_txn();
    drive();
  endtask

  task automatic set_txn(input int idx, input logic we, input logic [AW-1:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
    pend[idx] = '{vld: 1'b1, we: we, addr: addr, be: be, wdata: wdata};
    drive();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt0"},   gnt0, 1'b0);
    check({tag, "_gnt1"},   gnt1, 1'b0);
    check({tag, "_rvalid0"}, rvalid0, 1'b0);
    check({tag, "_rvalid1"}, rvalid1, 1'b0);
    check({tag, "_err0"},   err0, 1'b0);
    check({tag, "_err1"},   err1, 1'b0);
    check({tag, "_rdata0"}, rdata0, 32'h0);
    check({tag, "_rdata1"}, rdata1, 32'h0);
    check({tag, "_ram_en"}, ram_en, 1'b0);
    check({tag, "_fetch"},  fetch_en, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    logic [1:0] gseq [4];

    rst_ni = 1'b0; loader_done = 1'b0; rand_en = 0; load = 0;
    pend[0] = '0; pend[1] = '0;
    model_reset();
    set_txn(0, 1'b0, 22'h0, 4'hF, 32'h0);
    set_txn(1, 1'b0, 22'h0, 4'hF, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs("reset");
    end
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // BOOT: requester 0 holds a read of 0x0 and is never served.
    repeat (8) step();

    // BOOT: loader writes then reads back 0x100.
    set_txn(1, 1'b1, 22'h100, 4'hF, 32'hDEADBEEF);
    step();
    check("boot_wr_gnt1", {31'b0, obs_any & obs_gi}, 32'd1);
    set_txn(1, 1'b0, 22'h100, 4'hF, 32'h0);
    step();
    step();
    check("boot_readback_valid", obs_rvalid1, 1'b1);
    check("boot_readback", obs_rdata1, 32'hDEADBEEF);

    // BOOT: random loader traffic, core keeps asking.
    rand_en = 1; load = 50;
    repeat (40) step();

    // loader_done raised in the cycle of a loader grant.
    rand_en = 0;
    repeat (2) step();
    set_txn(1, 1'b1, 22'h104, 4'h3, 32'h12345678);
    loader_done = 1'b1;
    step();
    check("done_gnt1", {31'b0, obs_any & obs_gi}, 32'd1);
    k = 0;
    do begin
      step();
      k++;
    end while (!obs_fe && k < 10);
    check("fetch_latency", k, 3);

    // RUN: both requesters held continuously -> strict alternation.
    rand_en = 1; load = 100;
    pend[0] = rand_txn(); pend[1] = rand_txn(); drive();
    for (int i = 0; i < 4; i++) begin
      step();
      gseq[i] = {obs_any, obs_gi};
    end
    for (int i = 1; i < 4; i++)
      check("rr_alternate", {30'b0, gseq[i]}, {30'b0, 1'b1, ~gseq[i-1][0]});

    // RUN: random mixed traffic.
    load = 60;
    repeat (300) step();

    // RUN: out-of-range read from the core.
    rand_en = 0;
    repeat (3) step();
    set_txn(0, 1'b0, 22'h080000, 4'hF, 32'h0);
    step();
    check("oor_ram_en", obs_ram_en, 1'b0);
    step();
    check("oor_err0", obs_err0, 1'b1);
    check("oor_rdata0", obs_rdata0, 32'h0);

    // Reset in the cycle after a grant drops the pending response.
    set_txn(0, 1'b0, 22'h4, 4'hF, 32'h0);
    step();
    rst_ni = 1'b0;
    set_txn(1, 1'b0, 22'h8, 4'hF, 32'h0);
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    check_reset_outputs("midreset_hold");
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // Back through BOOT (loader_done still high) into RUN with random traffic.
    rand_en = 1; load = 40;
    repeat (200) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
